// File: rtl/cell_plotter.sv
// Changed-cell plotter: queues (cell x, cell y, colour) events and expands each
// into a CELL_SIZE x CELL_SIZE block of pixel writes for the vga_adapter.
module cell_plotter #(
  parameter int GRID_W     = 4,
  parameter int GRID_H     = 4,
  parameter int CELL_SIZE  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int X_OFFSET   = 0,
  parameter int Y_OFFSET   = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  input  logic [2:0] in_color,
  input  logic       clear,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [7:0]    GW8        = 8'(GRID_W);
  localparam logic [7:0]    GH8        = 8'(GRID_H);
  localparam logic [8:0]    CELL9      = 9'(CELL_SIZE);
  localparam logic [8:0]    CELL_LAST  = 9'(CELL_SIZE - 1);
  localparam logic [8:0]    CLR_X_LAST = 9'(GRID_W * CELL_SIZE - 1);
  localparam logic [8:0]    CLR_Y_LAST = 9'(GRID_H * CELL_SIZE - 1);
  localparam logic [8:0]    X9         = 9'(X_OFFSET);
  localparam logic [8:0]    Y9         = 9'(Y_OFFSET);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

  // ---------------- event FIFO ----------------
  logic [18:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          fifo_full, fifo_empty;
  logic          accept, bad_event, push, pop;
  logic [18:0]   head;

  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign in_ready   = !fifo_full;
  assign accept     = in_valid && in_ready;
  assign bad_event  = (in_x >= GW8) || (in_y >= GH8);
  assign push       = accept && !bad_event;
  assign head       = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= {in_x, in_y, in_color};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_count <= 8'd0;
    end else if (accept && bad_event && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  // ---------------- raster state machine ----------------
  state_t     state_reg, state_next;
  logic [8:0] px_reg, px_next, py_reg, py_next;
  logic [7:0] cx_reg, cx_next, cy_reg, cy_next;
  logic [2:0] cc_reg, cc_next;
  logic       clear_pending_reg, pending_next;
  logic [7:0] x_next;
  logic [6:0] y_next;
  logic [2:0] colour_next;
  logic       plot_next;
  logic       decide, clear_done;

  always_comb begin
    state_next   = state_reg;
    px_next      = px_reg;
    py_next      = py_reg;
    cx_next      = cx_reg;
    cy_next      = cy_reg;
    cc_next      = cc_reg;
    x_next       = x;
    y_next       = y;
    colour_next  = colour;
    plot_next    = 1'b0;
    pending_next = clear_pending_reg | clear;
    pop          = 1'b0;
    decide       = 1'b0;
    clear_done   = 1'b0;

    unique case (state_reg)
      IDLE: decide = 1'b1;
      PAINT: begin
        plot_next   = 1'b1;
        x_next      = 8'(X9 + {1'b0, cx_reg} * CELL9 + px_reg);
        y_next      = 7'(Y9 + {1'b0, cy_reg} * CELL9 + py_reg);
        colour_next = cc_reg;
        if (px_reg == CELL_LAST) begin
          px_next = 9'd0;
          if (py_reg == CELL_LAST) decide = 1'b1;
          else                     py_next = py_reg + 9'd1;
        end else begin
          px_next = px_reg + 9'd1;
        end
      end
      CLEAR: begin
        plot_next   = 1'b1;
        x_next      = 8'(X9 + px_reg);
        y_next      = 7'(Y9 + py_reg);
        colour_next = 3'd0;
        if (px_reg == CLR_X_LAST) begin
          px_next = 9'd0;
          if (py_reg == CLR_Y_LAST) begin
            clear_done   = 1'b1;
            pending_next = 1'b0;
            decide       = 1'b1;
          end else begin
            py_next = py_reg + 9'd1;
          end
        end else begin
          px_next = px_reg + 9'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Cell/clear boundary: a pending clear wins over queued events.
    if (decide) begin
      px_next = 9'd0;
      py_next = 9'd0;
      if (clear_pending_reg && !clear_done) begin
        state_next = CLEAR;
      end else if (!fifo_empty) begin
        pop = 1'b1;
        {cx_next, cy_next, cc_next} = head;
        state_next = PAINT;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      px_reg            <= 9'd0;
      py_reg            <= 9'd0;
      cx_reg            <= 8'd0;
      cy_reg            <= 8'd0;
      cc_reg            <= 3'd0;
      clear_pending_reg <= 1'b0;
      x                 <= 8'd0;
      y                 <= 7'd0;
      colour            <= 3'd0;
      plot              <= 1'b0;
    end else begin
      state_reg         <= state_next;
      px_reg            <= px_next;
      py_reg            <= py_next;
      cx_reg            <= cx_next;
      cy_reg            <= cy_next;
      cc_reg            <= cc_next;
      clear_pending_reg <= pending_next;
      x                 <= x_next;
      y                 <= y_next;
      colour            <= colour_next;
      plot              <= plot_next;
    end
  end

  assign busy = (state_reg != IDLE) || !fifo_empty || clear_pending_reg;

endmodule

// File: tb/tb_cell_plotter.sv
// Directed bench for cell_plotter: a default-geometry instance and an offset
// instance, checked against hand-computed pixel rasters.
module tb_cell_plotter;

  logic       clock;
  logic       reset_n;
  logic       in_valid, clear;
  logic [7:0] in_x, in_y;
  logic [2:0] in_color;
  logic       in_ready, plot1, busy1;
  logic [7:0] x1, err1;
  logic [6:0] y1;
  logic [2:0] colour1;

  logic       in_valid2, clear2;
  logic [7:0] in_x2, in_y2;
  logic [2:0] in_color2;
  logic       in_ready2, plot2, busy2;
  logic [7:0] x2, err2;
  logic [6:0] y2;
  logic [2:0] colour2;

  logic       sel;
  logic       o_plot;
  logic [7:0] o_x;
  logic [6:0] o_y;
  logic [2:0] o_colour;

  int errors = 0;
  int checks = 0;

  cell_plotter dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_color(in_color), .clear(clear),
    .x(x1), .y(y1), .colour(colour1), .plot(plot1), .busy(busy1), .err_count(err1)
  );

  cell_plotter #(.X_OFFSET(100), .Y_OFFSET(50)) dut_off (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_x(in_x2), .in_y(in_y2), .in_color(in_color2), .clear(clear2),
    .x(x2), .y(y2), .colour(colour2), .plot(plot2), .busy(busy2), .err_count(err2)
  );

  assign o_plot   = sel ? plot2   : plot1;
  assign o_x      = sel ? x2      : x1;
  assign o_y      = sel ? y2      : y1;
  assign o_colour = sel ? colour2 : colour1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_plot(input string tag, input int budget);
    int n = 0;
    while (o_plot !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(o_plot), 32'd1);
  endtask

  // Called on the negedge showing the cell's first pixel; leaves on its last.
  // act_at injects a clear pulse and a (0,0,5) push on the main instance.
  task automatic expect_cell(input string tag, input int cx, input int cy, input int col,
                             input int xo, input int yo, input int act_at);
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clock);
      if (i == act_at) clear = 1'b1;
      if (i == act_at + 1) begin
        clear = 1'b0; in_valid = 1'b1; in_x = 8'd0; in_y = 8'd0; in_color = 3'd5;
      end
      if (i == act_at + 2) in_valid = 1'b0;
      if (!(o_plot === 1'b1 && int'(o_x) == xo + cx * 8 + i % 8 &&
            int'(o_y) == yo + cy * 8 + i / 8 && int'(o_colour) == col)) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic push1(input int ex, input int ey, input int ec);
    in_valid = 1'b1; in_x = 8'(ex); in_y = 8'(ey); in_color = 3'(ec);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  initial begin
    int k, first_low, bad;
    reset_n = 1'b0; sel = 1'b0;
    in_valid = 0; in_x = 0; in_y = 0; in_color = 0; clear = 0;
    in_valid2 = 0; in_x2 = 0; in_y2 = 0; in_color2 = 0; clear2 = 0;
    do_reset();

    // ---- 1: reset state and a single cell
    check("rst_plot", 32'(plot1), 0);
    check("rst_x", 32'(x1), 0);
    check("rst_y", 32'(y1), 0);
    check("rst_colour", 32'(colour1), 0);
    check("rst_err", 32'(err1), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy1), 0);
    push1(2, 1, 7);
    check("t1_lat_n", 32'(plot1), 0);
    @(negedge clock);
    check("t1_lat_n1", 32'(plot1), 0);
    @(negedge clock);
    check("t1_first_x", 32'(x1), 16);
    check("t1_first_y", 32'(y1), 8);
    expect_cell("t1_cell21", 2, 1, 7, 0, 0, 999);
    check("t1_last_x", 32'(x1), 23);
    check("t1_last_y", 32'(y1), 15);
    @(negedge clock);
    check("t1_done_plot", 32'(plot1), 0);
    check("t1_done_busy", 32'(busy1), 0);

    // ---- 2: 20 back-to-back events against a 16-entry FIFO
    do_reset();
    k = 0; first_low = -1;
    fork
      begin
        int n = 0;
        logic acc;
        in_valid = 1'b1; in_x = 0; in_y = 0; in_color = 0;
        while (k < 20 && n < 3000) begin
          acc = in_ready;
          if (!acc && first_low < 0) first_low = k;
          @(negedge clock);
          n++;
          if (acc) begin
            k++;
            if (k < 20) begin
              in_x = 8'(k % 4); in_y = 8'((k / 4) % 4); in_color = 3'(k % 8);
            end else begin
              in_valid = 1'b0;
            end
          end
        end
        in_valid = 1'b0;
      end
      begin
        wait_plot("t2_start", 10);
        for (int c = 0; c < 20; c++) begin
          if (c > 0) @(negedge clock);
          expect_cell($sformatf("t2_cell%0d", c), c % 4, (c / 4) % 4, c % 8, 0, 0, 999);
        end
      end
    join
    check("t2_accept_before_full", 32'(first_low), 17);
    check("t2_accepted", 32'(k), 20);
    @(negedge clock);
    check("t2_done_plot", 32'(plot1), 0);
    check("t2_done_busy", 32'(busy1), 0);

    // ---- 3: out-of-range events and err_count saturation
    do_reset();
    push1(4, 0, 1);
    push1(0, 4, 2);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (plot1 || !in_ready) bad++;
      @(negedge clock);
    end
    check("t3_noplot", 32'(bad), 0);
    check("t3_err2", 32'(err1), 2);
    check("t3_busy", 32'(busy1), 0);
    in_valid = 1'b1; in_x = 8'd200; in_y = 8'd0;
    bad = 0;
    for (int i = 0; i < 253; i++) begin
      @(negedge clock);
      if (plot1 || !in_ready) bad++;
    end
    check("t3_err255", 32'(err1), 255);
    for (int i = 0; i < 5; i++) @(negedge clock);
    in_valid = 1'b0;
    check("t3_err_hold", 32'(err1), 255);
    check("t3_stream_quiet", 32'(bad), 0);

    // ---- 4: clear during a cell, then queued cell after the clear
    do_reset();
    push1(1, 1, 7);
    wait_plot("t4_start", 10);
    expect_cell("t4_cell11", 1, 1, 7, 0, 0, 9);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clock);
      if (!(plot1 === 1'b1 && int'(x1) == i % 32 && int'(y1) == i / 32 && colour1 == 3'd0)) bad++;
    end
    check("t4_clear_raster", 32'(bad), 0);
    @(negedge clock);
    expect_cell("t4_cell00", 0, 0, 5, 0, 0, 999);
    @(negedge clock);
    check("t4_done_plot", 32'(plot1), 0);
    check("t4_done_busy", 32'(busy1), 0);

    // ---- 5: reset in the middle of painting with events queued
    do_reset();
    push1(9, 9, 1);
    for (int e = 0; e < 4; e++) push1(e, 0, e + 1);
    wait_plot("t5_start", 10);
    for (int i = 1; i < 30; i++) @(negedge clock);
    check("t5_pre_busy", 32'(busy1), 1);
    check("t5_pre_err", 32'(err1), 1);
    reset_n = 1'b0;
    @(negedge clock);
    check("t5_rst_plot", 32'(plot1), 0);
    check("t5_rst_busy", 32'(busy1), 0);
    check("t5_rst_err", 32'(err1), 0);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (plot1 || busy1) bad++;
    end
    check("t5_after_quiet", 32'(bad), 0);

    // ---- 6: offset grid origin
    sel = 1'b1;
    in_valid2 = 1'b1; in_x2 = 8'd3; in_y2 = 8'd3; in_color2 = 3'd2;
    @(negedge clock);
    in_valid2 = 1'b0;
    wait_plot("t6_start", 10);
    check("t6_first_x", 32'(x2), 124);
    check("t6_first_y", 32'(y2), 74);
    expect_cell("t6_cell33", 3, 3, 2, 100, 50, 999);
    check("t6_last_x", 32'(x2), 131);
    check("t6_last_y", 32'(y2), 81);
    @(negedge clock);
    check("t6_done_plot", 32'(plot2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cell_plotter.md
Name: cell_plotter

Overview:
- Consumer end of the simulation's changed-cell stream. Accepts (cell x, cell y, colour) events through a valid/ready handshake and buffers them in a FIFO.
- Expands each event into a CELL_SIZE x CELL_SIZE block of single-pixel writes on the vga_adapter plot interface (x, y, colour, plot).
- Also provides a clear-grid command that blanks the whole grid region to colour 0.

Parameters:
- GRID_W, 4, grid width in cells.
- GRID_H, 4, grid height in cells.
- CELL_SIZE, 8, pixels per cell side; power of two, 1..16.
- FIFO_DEPTH, 16, event FIFO entries; power of two.
- X_OFFSET, 0, pixel x of grid origin.
- Y_OFFSET, 0, pixel y of grid origin.
- Legal parameter sets satisfy X_OFFSET+GRID_W*CELL_SIZE <= 160 and Y_OFFSET+GRID_H*CELL_SIZE <= 120.

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  event valid
- in_ready  out  1  event accepted when in_valid & in_ready at a rising edge
- in_x  in  8  cell column
- in_y  in  8  cell row
- in_color  in  3  cell colour
- clear  in  1  one-cycle pulse: request grid blank
- x  out  8  pixel x to vga_adapter
- y  out  7  pixel y to vga_adapter
- colour  out  3  pixel colour to vga_adapter
- plot  out  1  pixel write strobe
- busy  out  1  any work pending or in progress
- err_count  out  8  count of dropped out-of-range events, saturating

Behaviour:
Reset (clock with reset_n=0):
- FIFO emptied, clear_pending=0, state=IDLE.
- plot=0, x=0, y=0, colour=0, err_count=0.
- in_ready=1 from the first post-reset cycle; busy=0.
- Reset mid-operation aborts painting: plot is 0 after the reset edge, and queued events and any pending clear are discarded.

Input handshake:
- in_ready = !fifo_full (combinational from the count).
- An accepted event with in_x >= GRID_W or in_y >= GRID_H is not written to the FIFO; err_count increments, holding at 255.
- A push and a pop in the same cycle are legal when not full. An event presented while full is not accepted and must be held by the producer.

Clear:
- A clear pulse sets clear_pending. The pulse is ignored while clear_pending is already set.

State machine (IDLE, PAINT, CLEAR):
- Outputs x/y/colour/plot are registered.
- IDLE:
  - If clear_pending, go to CLEAR and load the first pixel (X_OFFSET, Y_OFFSET, colour 0).
  - Else if the FIFO is non-empty, pop the head event into cx/cy/cc, go to PAINT, and load pixel (px=0, py=0).
  - Otherwise plot=0.
- PAINT:
  - Each cycle plot=1, x = X_OFFSET + cx*CELL_SIZE + px, y = Y_OFFSET + cy*CELL_SIZE + py, colour=cc.
  - Raster order: px increments first, wrapping to 0 and incrementing py.
  - After pixel (CELL_SIZE-1, CELL_SIZE-1), the same cycle applies the IDLE decision. Back-to-back cells therefore have no idle gap.
  - A cell occupies exactly CELL_SIZE^2 plot cycles.
- CLEAR:
  - Raster over the full grid region, GRID_W*CELL_SIZE by GRID_H*CELL_SIZE pixels, colour 0, plot=1 every cycle.
  - On the last pixel, clear_pending is cleared, then the IDLE decision is applied.
  - FIFO contents are preserved and drawn after the clear.

Ordering and arithmetic:
- Clear takes priority over the FIFO, but only at cell boundaries; a cell in progress always completes.
- Latency: an event accepted at edge N into an empty, idle block gives plot=1 from edge N+2.
- Pixel arithmetic is computed at 9 bits, then truncated to the 8-bit x and 7-bit y outputs.

busy:
- busy = (state != IDLE) | !fifo_empty | clear_pending.

Test Plan:
1. Defaults; reset, push (2,1,3'b111) -> 64 consecutive plot cycles starting 2 edges after accept; first pixel (16,8), last (23,15), colour 7; then plot=0, busy=0.
2. Hold in_valid with 20 distinct valid events on consecutive cycles from idle -> exactly 17 accepted before in_ready falls; in_ready re-rises one cycle after cell 0's 64th pixel; all 20 cells eventually painted in push order, 64 plots each, no gaps.
3. Push (4,0) then (0,4) -> no plot, err_count=2, in_ready stays 1; with err_count at 255, a further bad push leaves it at 255.
4. Push (1,1,7), pulse clear at the 10th pixel, push (0,0,5) -> cell (1,1) completes its 64 pixels, then 1024 colour-0 plots over x 0..31, y 0..31, then cell (0,0) painted in colour 5.
5. Reset asserted during the 30th pixel of a cell with 3 events queued -> plot=0 after the edge, busy=0, err_count=0, no further plots after release.
6. X_OFFSET=100, Y_OFFSET=50; push (3,3,2) -> x 124..131, y 74..81, colour 2.
